// File: rtl/hs_fifo_pkt_writer_pkg.sv
// Shared typedefs and constants for the packet-mode FIFO writer.
// Holds the writer FSM encoding, the default counter width and the violation rule.
package hs_fifo_pkt_writer_pkg;

   localparam int unsigned DEF_CNT_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PASS    = 2'd1,
      S_DISCARD = 2'd2
   } pkt_state_t;

   // A beat poisons its packet if flagged bad, or if it is the last legal slot but not the end.
   function automatic logic is_violation(input logic err, input logic at_max, input logic last);
      return err | (at_max & ~last);
   endfunction

endpackage

// File: rtl/hs_fifo_pkt_writer_oreg.sv
// Single-entry output register driving the FIFO write port.
// Payload is not reset; only the control fields are cleared.
module hs_fifo_pkt_writer_oreg #(
   parameter type DATA_TYPE = logic
) (
   input  logic     clk,
   input  logic     aresetn,
   input  logic     load,
   input  DATA_TYPE load_data,
   input  logic     load_last,
   input  logic     load_drop,
   input  logic     wready,
   output logic     wvalid,
   output DATA_TYPE wdata,
   output logic     wlast,
   output logic     wdrop
);

   // Control fields: load a new beat, retire on handshake, otherwise hold.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wvalid <= 1'b0;
         wlast  <= 1'b0;
         wdrop  <= 1'b0;
      end else if (load) begin
         wvalid <= 1'b1;
         wlast  <= load_last;
         wdrop  <= load_drop;
      end else if (wready) begin
         wvalid <= 1'b0;
      end else begin
         wvalid <= wvalid;
      end
   end

   // Payload register, deliberately without reset.
   always_ff @(posedge clk) begin
      if (load) begin
         wdata <= load_data;
      end else begin
         wdata <= wdata;
      end
   end

endmodule

// File: rtl/hs_fifo_pkt_writer.sv
// Packet writer in front of a packet-mode FIFO: enforces MAX_PKT_LEN, turns bad or
// over-long packets into a drop beat, swallows their remainder and counts outcomes.
module hs_fifo_pkt_writer
   import hs_fifo_pkt_writer_pkg::*;
#(
   parameter type         DATA_TYPE   = logic,
   parameter int unsigned MAX_PKT_LEN = 16,
   parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  DATA_TYPE             in_data,
   input  logic                 in_last,
   input  logic                 in_error,
   output logic                 wvalid,
   input  logic                 wready,
   output DATA_TYPE             wdata,
   output logic                 wlast,
   output logic                 wdrop,
   output logic [CNT_WIDTH-1:0] pkt_ok_cnt,
   output logic [CNT_WIDTH-1:0] pkt_drop_cnt
);

   localparam int unsigned          IDX_W   = $clog2(MAX_PKT_LEN + 1);
   localparam logic [IDX_W-1:0]     IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(MAX_PKT_LEN);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   pkt_state_t       state_r;
   logic [IDX_W-1:0] beat_idx_r;
   logic [IDX_W-1:0] cur_idx_s;
   logic             accept_s;
   logic             violation_s;
   logic             load_s;
   logic             commit_s;

   assign in_ready    = !wvalid || wready;
   assign accept_s    = in_valid && in_ready;
   assign cur_idx_s   = beat_idx_r + IDX_ONE;
   assign violation_s = is_violation(in_error, cur_idx_s == IDX_MAX, in_last);
   assign load_s      = accept_s && (state_r != S_DISCARD);
   assign commit_s    = wvalid && wready && wlast;

   hs_fifo_pkt_writer_oreg #(
      .DATA_TYPE (DATA_TYPE)
   ) u_oreg (
      .clk       (clk),
      .aresetn   (aresetn),
      .load      (load_s),
      .load_data (in_data),
      .load_last (in_last | violation_s),
      .load_drop (violation_s),
      .wready    (wready),
      .wvalid    (wvalid),
      .wdata     (wdata),
      .wlast     (wlast),
      .wdrop     (wdrop)
   );

   // Packet FSM and beat index; a violation always ends the beat stream to the FIFO.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_r    <= S_IDLE;
         beat_idx_r <= '0;
      end else begin
         case (state_r)
            S_IDLE, S_PASS: begin
               if (accept_s) begin
                  if (violation_s) begin
                     state_r    <= in_last ? S_IDLE : S_DISCARD;
                     beat_idx_r <= '0;
                  end else if (in_last) begin
                     state_r    <= S_IDLE;
                     beat_idx_r <= '0;
                  end else begin
                     state_r    <= S_PASS;
                     beat_idx_r <= cur_idx_s;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            S_DISCARD: begin
               if (accept_s && in_last) begin
                  state_r <= S_IDLE;
               end else begin
                  state_r <= S_DISCARD;
               end
               beat_idx_r <= '0;
            end
            default: begin
               state_r    <= S_IDLE;
               beat_idx_r <= '0;
            end
         endcase
      end
   end

   // Outcome counters, bumped when the FIFO takes a terminating beat; saturating.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_ok_cnt   <= '0;
         pkt_drop_cnt <= '0;
      end else if (commit_s) begin
         if (wdrop) begin
            if (pkt_drop_cnt != CNT_MAX) pkt_drop_cnt <= pkt_drop_cnt + CNT_ONE;
            else                         pkt_drop_cnt <= pkt_drop_cnt;
         end else begin
            if (pkt_ok_cnt != CNT_MAX) pkt_ok_cnt <= pkt_ok_cnt + CNT_ONE;
            else                       pkt_ok_cnt <= pkt_ok_cnt;
         end
      end else begin
         pkt_ok_cnt   <= pkt_ok_cnt;
         pkt_drop_cnt <= pkt_drop_cnt;
      end
   end

endmodule

// File: tb/tb_hs_fifo_pkt_writer.sv
// Scoreboard bench for hs_fifo_pkt_writer with MAX_PKT_LEN=4, CNT_WIDTH=2, 8-bit beats.
module tb_hs_fifo_pkt_writer;

   localparam int MAXL = 4;
   localparam int CW   = 2;
   localparam int SAT  = 3;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_data = 8'h00;
   logic          in_last = 1'b0;
   logic          in_error = 1'b0;
   logic          wvalid;
   logic          wready = 1'b1;
   logic [7:0]    wdata;
   logic          wlast;
   logic          wdrop;
   logic [CW-1:0] pkt_ok_cnt;
   logic [CW-1:0] pkt_drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_fwd_cyc = -10;

   logic [9:0] exp_q[$];   // {data, last, drop}
   int  m_idx = 0;
   bit  m_disc = 1'b0;
   int  exp_ok = 0;
   int  exp_drop = 0;

   hs_fifo_pkt_writer #(
      .DATA_TYPE   (logic [7:0]),
      .MAX_PKT_LEN (MAXL),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_error     (in_error),
      .wvalid       (wvalid),
      .wready       (wready),
      .wdata        (wdata),
      .wlast        (wlast),
      .wdrop        (wdrop),
      .pkt_ok_cnt   (pkt_ok_cnt),
      .pkt_drop_cnt (pkt_drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference behaviour for one accepted beat: queue what the FIFO should see.
   task automatic model_accept(input logic [7:0] d, input bit last, input bit err);
      int idx;
      bit viol;
      if (m_disc) begin
         if (last) m_disc = 1'b0;
      end else begin
         idx  = m_idx + 1;
         viol = err || (idx == MAXL && !last);
         last_fwd_cyc = cyc;
         if (viol) begin
            exp_q.push_back({d, 1'b1, 1'b1});
            if (exp_drop < SAT) exp_drop++;
            m_idx  = 0;
            m_disc = !last;
         end else begin
            exp_q.push_back({d, last, 1'b0});
            if (last) begin
               if (exp_ok < SAT) exp_ok++;
               m_idx = 0;
            end else begin
               m_idx = idx;
            end
         end
      end
   endtask

   // Scoreboard side: compare every FIFO write handshake and the 1-cycle latency.
   always @(negedge clk) begin
      if (aresetn) begin
         if (cyc == last_fwd_cyc + 1) check_eq("latency_wvalid", 32'(wvalid), 32'd1);
         if (wvalid && wready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_beat", {22'd0, wdata, wlast, wdrop}, 32'h3ff);
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               check_eq("wdata", 32'(wdata), 32'(e[9:2]));
               check_eq("wlast", 32'(wlast), 32'(e[1]));
               check_eq("wdrop", 32'(wdrop), 32'(e[0]));
            end
         end
      end
   end

   task automatic send_beat(input logic [7:0] d, input bit last, input bit err);
      int waited;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_error = err;
      waited   = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 50) begin
            check_eq("accept_timeout", 32'(waited), 32'd0);
            break;
         end
      end
      if (in_ready) model_accept(d, last, err);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] base, input int len, input int err_at);
      for (int i = 1; i <= len; i++)
         send_beat(base + 8'(i), i == len, i == err_at);
   endtask

   task automatic drain_and_count(input string tag);
      wready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      check_eq({tag, "_ok_cnt"}, 32'(pkt_ok_cnt), 32'(exp_ok));
      check_eq({tag, "_drop_cnt"}, 32'(pkt_drop_cnt), 32'(exp_drop));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_wvalid"}, 32'(wvalid), 32'd0);
      check_eq({tag, "_wlast"}, 32'(wlast), 32'd0);
      check_eq({tag, "_wdrop"}, 32'(wdrop), 32'd0);
      check_eq({tag, "_ok"}, 32'(pkt_ok_cnt), 32'd0);
      check_eq({tag, "_drop"}, 32'(pkt_drop_cnt), 32'd0);
      check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic do_reset();
      aresetn  = 1'b0;
      in_valid = 1'b0;
      wready   = 1'b1;
      exp_q.delete();
      m_idx = 0; m_disc = 1'b0; exp_ok = 0; exp_drop = 0;
      last_fwd_cyc = -10;
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      aresetn = 1'b1;
   endtask

   initial begin
      logic [7:0] held;
      int c0;

      do_reset();

      // Three-beat good packet.
      send_pkt(8'hA0, 3, 0);
      drain_and_count("pkt3");

      // Exact-length packet passes; over-long packet is cut at beat 4.
      do_reset();
      send_pkt(8'h10, 4, 0);
      send_pkt(8'h20, 6, 0);
      drain_and_count("overlong");

      // Error on beat 2, then a clean packet, a single-beat packet and a bad single beat.
      do_reset();
      send_pkt(8'h30, 3, 2);
      send_pkt(8'h40, 2, 0);
      send_pkt(8'h50, 1, 0);
      send_pkt(8'h60, 1, 1);
      drain_and_count("error");

      // Back-pressure mid-packet.
      do_reset();
      send_beat(8'h71, 1'b0, 1'b0);
      wready = 1'b0;
      @(negedge clk);
      held = wdata;
      check_eq("stall_wvalid", 32'(wvalid), 32'd1);
      repeat (5) begin
         @(negedge clk);
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
         check_eq("stall_wdata", 32'(wdata), 32'(held));
      end
      @(posedge clk);
      #1;
      wready = 1'b1;
      send_beat(8'h72, 1'b0, 1'b0);
      send_beat(8'h73, 1'b1, 1'b0);
      drain_and_count("stall");

      // Five back-to-back good packets: full rate and counter saturation.
      do_reset();
      c0 = cyc;
      for (int p = 0; p < 5; p++) send_pkt(8'h80 + 8'(p * 16), 2, 0);
      check_eq("throughput_cycles", 32'(cyc - c0), 32'd10);
      drain_and_count("saturate");
      check_eq("saturate_value", 32'(pkt_ok_cnt), 32'd3);

      // Reset asserted while beat 2 is presented.
      do_reset();
      send_beat(8'h91, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h92;
      in_last  = 1'b0;
      in_error = 1'b0;
      #2;
      aresetn = 1'b0;
      #1;
      check_reset_outputs("midpkt_reset");
      in_valid = 1'b0;
      exp_q.delete();
      m_idx = 0; m_disc = 1'b0; exp_ok = 0; exp_drop = 0;
      last_fwd_cyc = -10;
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      send_pkt(8'hB0, 2, 0);
      drain_and_count("post_reset");
      check_eq("post_reset_ok_is_1", 32'(pkt_ok_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hs_fifo_pkt_writer.md
HS_FIFO_PKT_WRITER -- requirements
Module: hs_fifo_pkt_writer

Interface
REQ-001 Parameter DATA_TYPE, default logic, type of one beat.
REQ-002 Parameter MAX_PKT_LEN, default 16, range 1-16777216, maximum beats per packet; SHALL be <= depth of the downstream packet-mode FIFO.
REQ-003 Parameter CNT_WIDTH, default 32, width of the statistics counters.
REQ-004 Port clk  input  1  the single clock; all logic SHALL sample on its rising edge.
REQ-005 Port aresetn  input  1  asynchronous, active-low reset.
REQ-006 Ports in_valid/in_ready  input/output  1/1  upstream stream handshake.
REQ-007 Ports in_data/in_last/in_error  input  DATA_TYPE/1/1  upstream beat, end-of-packet, and bad-packet marker.
REQ-008 Ports wvalid/wready  output/input  1/1  FIFO write handshake.
REQ-009 Ports wdata/wlast/wdrop  output  DATA_TYPE/1/1  FIFO write beat, end-of-packet, and drop-current-packet.
REQ-010 Ports pkt_ok_cnt/pkt_drop_cnt  output  CNT_WIDTH/CNT_WIDTH  committed and dropped packet counts.

Function
REQ-011 The block SHALL own a single output register (wvalid/wdata/wlast/wdrop), and in_ready SHALL be !wvalid || wready (combinational).
REQ-012 An input beat is accepted when in_valid && in_ready; a forwarded beat SHALL appear on wvalid exactly 1 cycle after acceptance.
REQ-013 Output register fields SHALL stay stable while wvalid && !wready.
REQ-014 Beat counter beat_idx (width $clog2(MAX_PKT_LEN+1)) SHALL count accepted beats of the current packet, 1-based; it clears on any terminating beat.
REQ-015 The FSM SHALL have states S_IDLE (no beat of the packet accepted), S_PASS (mid-packet), and S_DISCARD (consuming the remainder of a rejected packet).
REQ-016 A beat is a violation when in_error=1, or when beat_idx==MAX_PKT_LEN and in_last=0.
REQ-017 In S_IDLE/S_PASS, a non-violating beat SHALL be forwarded with wdrop=0 and wlast=in_last; the next state is S_IDLE if in_last=1, else S_PASS.
REQ-018 In S_IDLE/S_PASS, a violating beat SHALL be forwarded with wdrop=1 and wlast=1; the next state is S_IDLE if in_last=1, else S_DISCARD.
REQ-019 In S_DISCARD, beats SHALL be accepted but not forwarded (in_ready=1 once the output register is free); in_last=1 returns the FSM to S_IDLE.
REQ-020 The FIFO SHALL never receive more than MAX_PKT_LEN beats of one packet.
REQ-021 Counters SHALL increment when a terminating beat (wlast=1) is accepted by the FIFO: pkt_drop_cnt if wdrop=1, else pkt_ok_cnt.
REQ-022 Counters SHALL saturate at all-ones.
REQ-023 A single-beat packet (in_last=1 on the first beat) SHALL be forwarded as one beat with wlast=1.
REQ-024 Back-to-back packets SHALL sustain 1 beat/cycle with no idle cycle between packets.

Reset
REQ-025 While aresetn=0: wvalid=0, wlast=0, wdrop=0, FSM=S_IDLE, beat_idx=0, both counters=0, and wdata SHALL NOT be reset.
REQ-026 Reset asserted mid-packet SHALL abandon the packet with no drop beat emitted; the first post-reset beat starts a new packet.

Structure
REQ-027 The FSM state enum and the counter-width constant SHALL live in the shared FIFO typedefs package.
REQ-028 The output register SHALL be a sub-module named hs_fifo_pkt_writer_oreg; the FSM and counters SHALL stay in the top module.

Verification
REQ-029 MAX_PKT_LEN=4, packet of 3 beats D0-D2 with wready=1 -> wvalid is 1 cycles 1-3; wlast=1 on D2 only; pkt_ok_cnt=1.
REQ-030 MAX_PKT_LEN=4, 6-beat packet -> 4 beats forwarded, beat 4 has wdrop=1 and wlast=1; beats 5-6 are consumed but not forwarded; pkt_drop_cnt=1.
REQ-031 in_error=1 on beat 2 of a 3-beat packet -> beat 2 is forwarded with wdrop=1 and wlast=1; beat 3 is swallowed; the next packet passes cleanly.
REQ-032 wready=0 for 5 cycles mid-packet -> in_ready=0 and wdata is held stable; no beat is lost or duplicated after wready=1.
REQ-033 CNT_WIDTH=2, 5 good packets -> pkt_ok_cnt sticks at 3.
REQ-034 aresetn pulsed low during beat 2 of a packet -> all outputs are at reset values, and a following 2-beat packet yields pkt_ok_cnt=1.
